fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter feeding an async FIFO write port
// Revision 1.0
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int DATA_SIZE = 8,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         w_clk,
  input  logic                         w_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_w_full,
  output logic                         fifo_w_en,
  output logic [ID_W+DATA_SIZE-1:0]    fifo_w_data,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     owner_nxt;
  logic [ID_W-1:0]     last_id;
  logic [ID_W-1:0]     last_id_nxt;
  logic [ID_W-1:0]     grant_id_nxt;
  logic [ID_W-1:0]     pick;
  logic [ID_W-1:0]     probe;
  logic                found;
  logic [7:0]          beat_cnt;
  logic [7:0]          beat_cnt_nxt;
  logic                grant_valid_nxt;
  logic                owner_valid;
  logic [DATA_SIZE-1:0] owner_data;
  logic                beat;
  logic                last_beat;

  // Round-robin search: first valid requester starting just after last_id.
  // NUM_REQ is a power of two, so ID_W-bit addition wraps modulo NUM_REQ.
  always_comb begin
    pick  = '0;
    probe = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = last_id + ID_W'(1) + ID_W'(k);
      if (!found && req_valid[probe]) begin
        pick  = probe;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Ready is gated by full directly, so no write can ever reach a full FIFO.
  assign beat      = (state == GRANT) && owner_valid && !fifo_w_full;
  assign last_beat = (beat_cnt == 8'(MAX_BURST - 1));

  always_comb begin
    req_ready   = '0;
    fifo_w_en   = 1'b0;
    fifo_w_data = '0;
    if (state == GRANT && !fifo_w_full) begin
      req_ready[owner] = 1'b1;
    end
    if (beat) begin
      fifo_w_en   = 1'b1;
      fifo_w_data = {owner, owner_data};
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_id_nxt     = last_id;
    grant_id_nxt    = grant_id;
    beat_cnt_nxt    = beat_cnt;
    grant_valid_nxt = grant_valid;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = GRANT;
          owner_nxt       = pick;
          grant_id_nxt    = pick;
          beat_cnt_nxt    = 8'd0;
          grant_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          state_nxt       = IDLE;
          last_id_nxt     = owner;
          grant_valid_nxt = 1'b0;
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + 8'd1;
          if (last_beat) begin
            state_nxt       = IDLE;
            last_id_nxt     = owner;
            grant_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt       = IDLE;
        grant_valid_nxt = 1'b0;
      end
    endcase
  end

  // last_id resets to NUM_REQ-1 so the first search begins at requester 0.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_id     <= ID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      beat_cnt    <= 8'd0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_id     <= last_id_nxt;
      grant_id    <= grant_id_nxt;
      beat_cnt    <= beat_cnt_nxt;
      grant_valid <= grant_valid_nxt;
    end
  end

  a_no_write_when_full : assert property (
    @(posedge w_clk) disable iff (w_rst) !(fifo_w_en && fifo_w_full));
  a_ready_onehot : assert property (
    @(posedge w_clk) disable iff (w_rst) $onehot0(req_ready));

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter : directed and random checks against a transaction model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;
  localparam int MB  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             full;
  logic             en;
  logic [IDW+DW-1:0] wdata;
  logic             gv;
  logic [IDW-1:0]   gid;

  logic [NR-1:0]    b_valid = 4'b1001;
  logic [NR*DW-1:0] b_data  = '0;
  logic             b_full  = 1'b0;
  logic [NR-1:0]    b_ready;
  logic             b_en;
  logic [IDW+DW-1:0] b_wdata;
  logic             b_gv;
  logic [IDW-1:0]   b_gid;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .w_clk(clk), .w_rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_w_full(full), .fifo_w_en(en),
    .fifo_w_data(wdata), .grant_valid(gv), .grant_id(gid)
  );

  // Second instance with single-beat bursts and two permanently active requesters.
  fifo_wr_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR), .MAX_BURST(1)) dut_b (
    .w_clk(clk), .w_rst(rst), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .fifo_w_full(b_full), .fifo_w_en(b_en),
    .fifo_w_data(b_wdata), .grant_valid(b_gv), .grant_id(b_gid)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner = -1 means no grant in progress.
  int        m_owner, m_last, m_gid, m_beats;
  logic [DW-1:0] hd[NR];
  int        words_left[NR];
  bit        rand_mode;
  int        ph_cyc, full_lo, full_hi;
  int        n_wr_dut, n_wr_mdl, ph_en, ph_en_full, ph_id2;
  logic [IDW-1:0] a_seq[$];
  logic [IDW-1:0] b_seq[$];
  bit        b_track;
  logic      gv_prev, b_gv_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = NR - 1;
    m_gid     = 0;
    m_beats   = 0;
    gv_prev   = 1'b0;
    b_gv_prev = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gv"},    32'(gv),        32'd0);
    check({tag, "_gid"},   32'(gid),       32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_en"},    32'(en),        32'd0);
    check({tag, "_data"},  32'(wdata),     32'd0);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = rand_mode ? ($urandom_range(0, 3) != 0) : (words_left[i] > 0);
      req_data[i*DW +: DW] = hd[i];
    end
    full = rand_mode ? ($urandom_range(0, 3) == 0) : (ph_cyc >= full_lo && ph_cyc <= full_hi);
  endtask

  task automatic step_body();
    logic [NR-1:0]     exp_ready;
    logic              exp_en;
    logic [IDW+DW-1:0] exp_data;
    bit                acc;
    bit                hit;
    int                o;
    int                c;
    drive();
    #1;
    exp_ready = '0;
    exp_en    = 1'b0;
    exp_data  = '0;
    acc       = 1'b0;
    o         = m_owner;
    if (o >= 0) begin
      if (!full) exp_ready[o] = 1'b1;
      acc = req_valid[o] && !full;
      if (acc) begin
        exp_en   = 1'b1;
        exp_data = {IDW'(o), hd[o]};
      end
    end
    check("ready", 32'(req_ready), 32'(exp_ready));
    check("w_en",  32'(en),        32'(exp_en));
    check("w_data", 32'(wdata),    32'(exp_data));
    check("gnt_valid", 32'(gv),    32'(o >= 0));
    check("gnt_id", 32'(gid),      32'(m_gid));
    if (en) begin
      n_wr_dut++;
      ph_en++;
      if (wdata[IDW+DW-1:DW] == 2'd2) ph_id2++;
      if (ph_cyc >= full_lo && ph_cyc <= full_hi) ph_en_full++;
    end
    if (gv && !gv_prev) a_seq.push_back(gid);
    gv_prev = gv;
    if (b_track) begin
      check("b_en", 32'(b_en), 32'(b_gv));
      if (b_gv && !b_gv_prev) b_seq.push_back(b_gid);
      b_gv_prev = b_gv;
    end
    // advance the model to the state after the coming rising edge
    if (o < 0) begin
      hit = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!hit && req_valid[c]) begin
          hit     = 1'b1;
          m_owner = c;
          m_gid   = c;
          m_beats = 0;
        end
      end
    end else if (!req_valid[o]) begin
      m_last  = o;
      m_owner = -1;
    end else if (acc) begin
      n_wr_mdl++;
      hd[o] = DW'($urandom);
      if (words_left[o] > 0) words_left[o]--;
      m_beats++;
      if (m_beats == MB) begin
        m_last  = o;
        m_owner = -1;
      end
    end
    ph_cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    step_body();
  endtask

  task automatic phase_start();
    ph_cyc     = 0;
    ph_en      = 0;
    ph_en_full = 0;
    ph_id2     = 0;
    a_seq.delete();
  endtask

  int exp1[5] = '{0, 1, 2, 3, 0};
  int expb[4] = '{0, 3, 0, 3};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    rand_mode = 1'b0;
    b_track   = 1'b0;
    full_lo   = -1;
    full_hi   = -2;
    n_wr_dut  = 0;
    n_wr_mdl  = 0;
    for (int i = 0; i < NR; i++) begin
      hd[i]         = DW'($urandom);
      words_left[i] = 0;
    end
    model_reset();
    phase_start();
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    // All four requesters busy: 0,1,2,3,0 with full bursts.
    phase_start();
    for (int i = 0; i < NR; i++) words_left[i] = 1000;
    b_track = 1'b1;
    repeat (25) step();
    for (int i = 0; i < NR; i++) words_left[i] = 0;
    b_track = 1'b0;
    repeat (3) step();
    check("p1_ngrants", 32'(a_seq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("p1_order", (i < a_seq.size()) ? 32'(a_seq[i]) : 32'hFFFF_FFFF, 32'(exp1[i]));
    check("p1_writes", 32'(ph_en), 32'd20);
    for (int i = 0; i < 4; i++)
      check("b_alternate", (i < b_seq.size()) ? 32'(b_seq[i]) : 32'hFFFF_FFFF, 32'(expb[i]));

    // Requester 2 alone with three words, then 1 and 3 compete.
    phase_start();
    words_left[2] = 3;
    repeat (6) step();
    check("p2_id2_writes", 32'(ph_id2), 32'd3);
    check("p2_grant", (a_seq.size() > 0) ? 32'(a_seq[0]) : 32'hFFFF_FFFF, 32'd2);
    phase_start();
    words_left[1] = 1;
    words_left[3] = 1;
    repeat (8) step();
    check("p2_next_first", (a_seq.size() > 0) ? 32'(a_seq[0]) : 32'hFFFF_FFFF, 32'd3);
    check("p2_next_second", (a_seq.size() > 1) ? 32'(a_seq[1]) : 32'hFFFF_FFFF, 32'd1);

    // Requester 1 stalled by full for five cycles after its second beat.
    phase_start();
    words_left[1] = 4;
    full_lo = 3;
    full_hi = 7;
    repeat (12) step();
    check("p3_en_while_full", 32'(ph_en_full), 32'd0);
    check("p3_beats", 32'(ph_en), 32'd4);
    full_lo = -1;
    full_hi = -2;

    // Reset mid-burst after the first beat of requester 2.
    phase_start();
    words_left[2] = 4;
    repeat (2) step();
    @(negedge clk);
    drive();
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    for (int i = 0; i < NR; i++) words_left[i] = 0;
    req_valid = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    phase_start();
    words_left[1] = 2;
    words_left[3] = 2;
    step_body();
    repeat (9) step();
    check("p4_first_after_rst", (a_seq.size() > 0) ? 32'(a_seq[0]) : 32'hFFFF_FFFF, 32'd1);

    // Random valid/full traffic.
    rand_mode = 1'b1;
    repeat (10000) step();
    rand_mode = 1'b0;
    for (int i = 0; i < NR; i++) words_left[i] = 0;
    repeat (4) step();
    check("total_writes", 32'(n_wr_dut), 32'(n_wr_mdl));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
